// File: rtl/mod_updown_counter_if.sv
// mod_updown_counter_if: control and count bus for mod_updown_counter
interface mod_updown_counter_if #(parameter int WIDTH = 4);
  logic en;
  logic up;
  logic clear;
  logic load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic tc;
  modport master (output en, up, clear, load, load_val, input out, tc);
  modport slave (input en, up, clear, load, load_val, output out, tc);
endinterface

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: prescaled up/down counter with wrap or saturate and terminal-count pulse
module mod_updown_counter #(
  parameter int WIDTH = 4,
  parameter int MAX = 15,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input logic clk,
  input logic rst,
  mod_updown_counter_if.slave bus
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
  logic [PW-1:0] pre, pre_n;
  logic [WIDTH-1:0] cnt, cnt_n, stepped;
  logic tc_q, tc_n, step, at_bnd;
  always_comb begin
    step = bus.en && pre == PLAST;
    at_bnd = bus.up ? cnt == MAXV : cnt == '0;
    stepped = at_bnd ? (SATURATE != 0 ? cnt : (bus.up ? '0 : MAXV))
                     : (bus.up ? cnt + 1'b1 : cnt - 1'b1);
    pre_n = (bus.clear || bus.load) ? '0 : !bus.en ? pre : (pre == PLAST ? '0 : pre + 1'b1);
    cnt_n = bus.clear ? '0 : bus.load ? (bus.load_val > MAXV ? MAXV : bus.load_val)
          : step ? stepped : cnt;
    tc_n = !bus.clear && !bus.load && step && at_bnd;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      cnt <= '0;
      tc_q <= 1'b0;
    end else begin
      pre <= pre_n;
      cnt <= cnt_n;
      tc_q <= tc_n;
    end
  end
  assign bus.out = cnt;
  assign bus.tc = tc_q;
endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised synchronous up/down counter. It is the successor to the fixed 4-bit ripple counter. It adds configurable width and modulus, a wrap or saturate mode, direction control, clock-enable prescaling, synchronous load and clear, and a terminal-count pulse. It is used wherever the design needs a programmable event or cycle counter and is a drop-in for the old counter when parameters are left at their defaults.

## Interface
- WIDTH, 4: bit width of the count value.
- MAX, 15: terminal value. Count range is 0..MAX. Legal range is 1 ≤ MAX ≤ 2^WIDTH−1.
- SATURATE, 0: 0 = wrap at the boundaries; 1 = hold at the boundaries.
- PRESCALE, 1: number of enabled cycles per count step. Must be ≥ 1.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- en  input  1  count enable; advances the prescaler.
- up  input  1  direction: 1 = increment, 0 = decrement.
- clear  input  1  synchronous clear of count and prescaler.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value to load.
- out  output  WIDTH  current count (registered).
- tc  output  1  terminal-count pulse (registered, one cycle per event).

## Operation
- Priority per edge: rst > clear > load > step.
- rst (async): out=0, tc=0, prescaler=0, immediately and independent of clk.
- clear: out=0, prescaler=0, tc=0.
- load: out=min(load_val, MAX), prescaler=0, tc=0. When load is asserted, en is ignored.
- Prescaler pre, range 0..PRESCALE−1:
  - when en=1 and no clear/load, pre advances: if pre==PRESCALE−1 then pre→0, otherwise pre+1.
  - when en=0, pre holds.
- step = en && pre==PRESCALE−1. With PRESCALE=1, step = en.
- Step when up=1:
  - out<MAX → out+1, tc=0.
  - out==MAX → out=0 (SATURATE=0) or hold at MAX (SATURATE=1), with tc=1.
- Step when up=0:
  - out>0 → out−1, tc=0.
  - out==0 → out=MAX (SATURATE=0) or hold at 0 (SATURATE=1), with tc=1.
- No step → out holds, tc=0.
- up may change on any cycle; it is sampled only on step edges.
- Arithmetic is WIDTH bits. out never exceeds MAX, including after a load.
- The prescaler uses a separate counter sized to $clog2(PRESCALE), minimum 1 bit.

## Timing
- Reset values: out=0, tc=0.
- Count latency: out reflects a step on the same edge that samples step=1. There is no extra pipeline stage.
- tc is asserted on the same edge as the boundary transition (for example, out MAX→0) and is high for exactly one cycle unless the next edge is also a boundary step.
- In SATURATE=1 mode, tc pulses on every step attempted at the boundary, so continuous enable at PRESCALE=1 while held at the boundary gives tc continuously high.
- First step after reset with en held high occurs on the PRESCALE-th rising edge.
- Load and clear take effect on the next edge, and the first subsequent step is PRESCALE enabled cycles later.
- rst deasserted mid-cycle: counting resumes from 0 on the first edge with rst low.

## Test plan
- Defaults (WIDTH=4, MAX=15, SATURATE=0, PRESCALE=1), en=1, up=1 after reset → out = 1,2,…,15,0 on edges 1..16; tc=1 only on edge 16.
- MAX=9, up=0 from reset, en=1 → edge 1: out=9, tc=1; edges 2..4: out = 8,7,6 with tc=0.
- MAX=9, SATURATE=1, load load_val=8, then up=1, en=1 → out = 8,9,9,9; tc=0 on the 8→9 step and tc=1 on each held step at 9. Then up=0 → out=8, tc=0.
- PRESCALE=3, en=1 → out increments on edges 3, 6, 9. Drop en for two cycles after edge 7 → next increment is delayed by 2 cycles, to edge 11.
- MAX=9, load_val=12 → out=9. Then load=1 and clear=1 together → out=0. Then load=1 with en=1 → loaded value, no step, prescaler restarts.
- Assert rst between edges while out=7 → out=0 and tc=0 before the next edge; release rst → counting restarts with out=1 on the first enabled edge (PRESCALE=1).
